// File: rtl/window_gen_5x5.sv
// window_gen_5x5
//   Streaming 5x5 sliding-window generator that feeds the conv stage.
//   It takes a zero-padded IMG_W x IMG_H image in raster order, one pixel
//   per accepted beat. It keeps four line buffers and a 5x5 window register.
//   It emits one 25-pixel window for every interior position, and each
//   window pixel is zero-extended to OUT_W bits.
//
// Ports
//   clk        : system clock, every flop on posedge
//   rst        : asynchronous, active-low reset
//   in_valid   : in_pixel / in_sof are valid
//   in_ready   : block can take a pixel this cycle
//   in_pixel   : padded-image pixel, raster order
//   in_sof     : marks pixel (0,0) of a frame, sampled on accept
//   win_valid  : win_pixels / win_row / win_col are valid
//   win_ready  : downstream takes the window
//   win_pixels : pixelN at [N*OUT_W-1:(N-1)*OUT_W]; pixel1 = top-left,
//                row-major, pixel25 = bottom-right
//   win_row    : output-image row of the window (0..IMG_H-K)
//   win_col    : output-image column of the window (0..IMG_W-K)
//   frame_done : one-cycle pulse after the handshake of the last window
module window_gen_5x5 #(
    parameter int IMG_W = 516,
    parameter int IMG_H = 516,
    parameter int K     = 5,
    parameter int PIX_W = 8,
    parameter int OUT_W = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PIX_W-1:0]       in_pixel,
    input  logic                   in_sof,
    output logic                   win_valid,
    input  logic                   win_ready,
    output logic [K*K*OUT_W-1:0]   win_pixels,
    output logic [9:0]             win_row,
    output logic [9:0]             win_col,
    output logic                   frame_done
);

    localparam int NPIX = K * K;
    localparam int CW   = $clog2(IMG_W);
    localparam int RW   = $clog2(IMG_H);

    localparam logic [CW-1:0] LAST_COL     = CW'(IMG_W - 1);
    localparam logic [RW-1:0] LAST_ROW     = RW'(IMG_H - 1);
    localparam logic [RW-1:0] FILL_ROW     = RW'(K - 2);
    localparam logic [CW-1:0] KM1_COL      = CW'(K - 1);
    localparam logic [RW-1:0] KM1_ROW      = RW'(K - 1);
    localparam logic [9:0]    LAST_WIN_ROW = 10'(IMG_H - K);
    localparam logic [9:0]    LAST_WIN_COL = 10'(IMG_W - K);

    typedef enum logic {S_FILL, S_RUN} state_t;

    function automatic logic [OUT_W-1:0] zext(input logic [PIX_W-1:0] p);
        return OUT_W'(p);
    endfunction

    // Line buffers: lb0 holds the row just above the current one, lb3 the oldest.
    logic [PIX_W-1:0] lb0_q [IMG_W];
    logic [PIX_W-1:0] lb1_q [IMG_W];
    logic [PIX_W-1:0] lb2_q [IMG_W];
    logic [PIX_W-1:0] lb3_q [IMG_W];

    logic [PIX_W-1:0] win_q   [NPIX];
    logic [PIX_W-1:0] win_d   [NPIX];
    logic [PIX_W-1:0] new_col [K];

    logic [CW-1:0]          col_q, col_d;
    logic [RW-1:0]          row_q, row_d;
    state_t                 state_q, state_d;
    logic                   win_valid_q, win_valid_d;
    logic [K*K*OUT_W-1:0]   win_pixels_q, win_pixels_d;
    logic [9:0]             win_row_q, win_row_d;
    logic [9:0]             win_col_q, win_col_d;
    logic                   frame_done_q, frame_done_d;

    logic          accept;
    logic          emit;
    logic [CW-1:0] col_cur;
    logic [RW-1:0] row_cur;

    // One output register, so the block can take a pixel whenever that
    // register is empty or is being emptied this cycle.
    assign in_ready = !win_valid_q || win_ready;
    assign accept   = in_valid && in_ready;

    // An in_sof beat is always pixel (0,0), whatever the counters hold.
    assign col_cur = in_sof ? '0 : col_q;
    assign row_cur = in_sof ? '0 : row_q;

    // Columns 0..K-2 of a row emit nothing. Their windows would still
    // contain columns left over from the previous row band.
    assign emit = accept && (state_q == S_RUN) && !in_sof && (col_cur >= KM1_COL);

    always_comb begin
        new_col[0] = lb3_q[col_cur];
        new_col[1] = lb2_q[col_cur];
        new_col[2] = lb1_q[col_cur];
        new_col[3] = lb0_q[col_cur];
        new_col[4] = in_pixel;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                if (c < K - 1) begin
                    win_d[r*K + c] = win_q[r*K + c + 1];
                end else begin
                    win_d[r*K + c] = new_col[r];
                end
            end
        end
    end

    // Pixel storage carries no reset. A window is only emitted after K rows
    // and K columns of the current frame have passed through it.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb3_q[col_cur] <= lb2_q[col_cur];
            lb2_q[col_cur] <= lb1_q[col_cur];
            lb1_q[col_cur] <= lb0_q[col_cur];
            lb0_q[col_cur] <= in_pixel;
            win_q          <= win_d;
        end
    end

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        state_d      = state_q;
        win_valid_d  = win_valid_q;
        win_pixels_d = win_pixels_q;
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
        frame_done_d = 1'b0;

        if (win_valid_q && win_ready) begin
            win_valid_d  = 1'b0;
            frame_done_d = (win_row_q == LAST_WIN_ROW) && (win_col_q == LAST_WIN_COL);
        end

        if (accept) begin
            if (col_cur == LAST_COL) begin
                col_d = '0;
                row_d = (row_cur == LAST_ROW) ? '0 : row_cur + 1'b1;
            end else begin
                col_d = col_cur + 1'b1;
                row_d = row_cur;
            end

            if (in_sof || ((row_cur == LAST_ROW) && (col_cur == LAST_COL))) begin
                state_d = S_FILL;
            end else if ((row_cur == FILL_ROW) && (col_cur == LAST_COL)) begin
                state_d = S_RUN;
            end
        end

        // A new window may load on the same edge as the old one's handshake.
        if (emit) begin
            win_valid_d = 1'b1;
            for (int n = 0; n < NPIX; n++) begin
                win_pixels_d[n*OUT_W +: OUT_W] = zext(win_d[n]);
            end
            win_row_d = 10'(row_cur - KM1_ROW);
            win_col_d = 10'(col_cur - KM1_COL);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q        <= '0;
            row_q        <= '0;
            state_q      <= S_FILL;
            win_valid_q  <= 1'b0;
            win_pixels_q <= '0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            state_q      <= state_d;
            win_valid_q  <= win_valid_d;
            win_pixels_q <= win_pixels_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign win_valid  = win_valid_q;
    assign win_pixels = win_pixels_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window_gen_5x5.sv
// Testbench for window_gen_5x5. It uses a reduced padded image (24 x 14) so
// that several whole frames fit in a short run. Every accepted pixel is
// written into a reference image at the bench's own raster position. Each
// interior position then pushes the 5x5 block cut directly from that image
// into a scoreboard queue. A separate monitor pops an entry on every window
// handshake and compares it.
module tb_window_gen_5x5;

    localparam int W  = 24;
    localparam int H  = 14;
    localparam int K  = 5;
    localparam int OW = 10;
    localparam int NW = (W - K + 1) * (H - K + 1);

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [7:0]         in_pixel = '0;
    logic               in_sof = 1'b0;
    logic               win_valid;
    logic               win_ready = 1'b1;
    logic [K*K*OW-1:0]  win_pixels;
    logic [9:0]         win_row;
    logic [9:0]         win_col;
    logic               frame_done;

    window_gen_5x5 #(.IMG_W(W), .IMG_H(H), .K(K), .PIX_W(8), .OUT_W(OW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pixel   (in_pixel),
        .in_sof     (in_sof),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_pixels (win_pixels),
        .win_row    (win_row),
        .win_col    (win_col),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [K*K*OW-1:0] pix;
        int                row;
        int                col;
        int                acc;
    } exp_t;

    exp_t       q[$];
    logic [7:0] img [H][W];
    int         mr = 0, mc = 0;
    int         errors = 0, checks = 0;
    int         cyc = 0;
    int         popped = 0;
    int         fd_count = 0, exp_fd = 0;
    int         rdy_mode = 0;
    int         stall_cnt = 0;
    bit         rand_valid = 1'b0;
    bit         in_reset = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: store the pixel at its raster position. At an
    // interior position, cut the 5x5 block that ends there.
    task automatic model_accept(input logic [7:0] pix, input bit sof);
        exp_t e;
        if (sof) begin
            mr = 0;
            mc = 0;
        end
        img[mr][mc] = pix;
        if (mr >= K - 1 && mc >= K - 1) begin
            e.pix = '0;
            for (int dr = 0; dr < K; dr++)
                for (int dc = 0; dc < K; dc++)
                    e.pix[(dr*K + dc)*OW +: OW] = {2'b00, img[mr-K+1+dr][mc-K+1+dc]};
            e.row = mr - K + 1;
            e.col = mc - K + 1;
            e.acc = cyc;
            q.push_back(e);
            if (e.row == H - K && e.col == W - K) exp_fd++;
        end
        mc++;
        if (mc == W) begin
            mc = 0;
            mr++;
            if (mr == H) mr = 0;
        end
    endtask

    task automatic push_pixel(input logic [7:0] pix, input bit sof);
        bit done = 1'b0;
        int tries = 0;
        while (!done) begin
            @(negedge clk);
            in_valid = rand_valid ? ($urandom_range(9) < 7) : 1'b1;
            in_pixel = pix;
            in_sof   = sof;
            #1;
            if (in_valid && in_ready) begin
                model_accept(pix, sof);
                done = 1'b1;
            end else begin
                tries++;
                if (tries > 500) begin
                    $display("FAIL input stall: in_ready stuck low, got 0, expected 1 within 500 cycles");
                    $fatal(1, "input stalled");
                end
            end
        end
    endtask

    task automatic send_pixels(input int from_idx, input int to_idx, input bit ramp,
                               input bit sof_first, input bit do_stall);
        logic [7:0] p;
        for (int idx = from_idx; idx <= to_idx; idx++) begin
            p = ramp ? 8'(((idx / W) * W + (idx % W)) % 256) : 8'($urandom);
            push_pixel(p, sof_first && (idx == 0));
            if (do_stall && idx == 7*W + 10) stall_cnt = 10;
        end
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        while (q.size() > 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("drain leftover windows", 256'(q.size()), 256'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        #3;
        in_reset = 1'b1;
        rst      = 1'b0;
        #1;
        chk("async reset win_valid", 256'(win_valid), 256'(0));
        chk("async reset frame_done", 256'(frame_done), 256'(0));
        q.delete();
        mr = 0;
        mc = 0;
        repeat (3) @(negedge clk);
        #3;
        rst      = 1'b0 | 1'b1;
        in_reset = 1'b0;
    endtask

    // Downstream ready: always high, random 50%, or forced low for stall_cnt cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (stall_cnt > 0) begin
                win_ready = 1'b0;
                stall_cnt--;
            end else if (rdy_mode == 0) begin
                win_ready = 1'b1;
            end else begin
                win_ready = 1'($urandom_range(1));
            end
        end
    end

    // Monitor: frame_done timing, hold-during-stall, latency and content.
    initial begin
        exp_t              e;
        bit                fd_pend = 1'b0;
        bit                stall_prev = 1'b0;
        bit                presented = 1'b0;
        logic [K*K*OW-1:0] hpix = '0;
        logic [9:0]        hrow = '0, hcol = '0;
        forever begin
            @(negedge clk);
            #2;
            if (in_reset || !rst) begin
                fd_pend    = 1'b0;
                stall_prev = 1'b0;
                presented  = 1'b0;
            end else begin
                chk("frame_done", 256'(frame_done), 256'(fd_pend));
                if (frame_done) fd_count++;
                fd_pend = 1'b0;
                if (stall_prev) begin
                    chk("stall hold win_valid", 256'(win_valid), 256'(1));
                    chk("stall hold win_pixels", 256'(win_pixels), 256'(hpix));
                    chk("stall hold win_row", 256'(win_row), 256'(hrow));
                    chk("stall hold win_col", 256'(win_col), 256'(hcol));
                end
                stall_prev = 1'b0;
                if (win_valid) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected window: got row %0d col %0d, expected no window", win_row, win_col);
                    end else begin
                        if (!presented) begin
                            chk("window latency", 256'(cyc - q[0].acc), 256'(1));
                            presented = 1'b1;
                        end
                        if (win_ready) begin
                            e = q.pop_front();
                            chk("win_row", 256'(win_row), 256'(e.row));
                            chk("win_col", 256'(win_col), 256'(e.col));
                            chk("win_pixels", 256'(win_pixels), 256'(e.pix));
                            popped++;
                            presented = 1'b0;
                            fd_pend = (e.row == H - K) && (e.col == W - K);
                        end else begin
                            chk("in_ready during stall", 256'(in_ready), 256'(0));
                            stall_prev = 1'b1;
                            hpix = win_pixels;
                            hrow = win_row;
                            hcol = win_col;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        #2;
        chk("reset win_valid", 256'(win_valid), 256'(0));
        chk("reset frame_done", 256'(frame_done), 256'(0));
        chk("reset win_row", 256'(win_row), 256'(0));
        chk("reset win_col", 256'(win_col), 256'(0));
        chk("reset win_pixels", 256'(win_pixels), 256'(0));
        chk("reset in_ready", 256'(in_ready), 256'(1));
        repeat (2) @(negedge clk);
        rst      = 1'b1;
        in_reset = 1'b0;

        // Ramp frame, full throughput.
        p0 = popped;
        send_pixels(0, W*H - 1, 1'b1, 1'b1, 1'b0);
        drain();
        chk("ramp frame window count", 256'(popped - p0), 256'(NW));

        // Random pixels, random valid/ready, plus a forced 10-cycle stall.
        rdy_mode   = 1;
        rand_valid = 1'b1;
        p0 = popped;
        send_pixels(0, W*H - 1, 1'b0, 1'b1, 1'b1);
        drain();
        chk("random frame window count", 256'(popped - p0), 256'(NW));

        // Ramp again under random handshakes.
        p0 = popped;
        send_pixels(0, W*H - 1, 1'b1, 1'b1, 1'b0);
        drain();
        chk("ramp backpressure window count", 256'(popped - p0), 256'(NW));

        // Resync: in_sof at (8,5) restarts the frame there.
        send_pixels(0, 8*W + 4, 1'b0, 1'b1, 1'b0);
        push_pixel(8'($urandom), 1'b1);
        send_pixels(1, W*H - 1, 1'b0, 1'b0, 1'b0);
        drain();

        // Reset during row 9. The next frame starts without in_sof.
        send_pixels(0, 9*W + 3, 1'b0, 1'b1, 1'b0);
        do_reset();
        p0 = popped;
        send_pixels(0, W*H - 1, 1'b0, 1'b0, 1'b0);
        drain();
        chk("post-reset frame window count", 256'(popped - p0), 256'(NW));

        chk("frame_done pulse count", 256'(fd_count), 256'(exp_fd));
        chk("frame_done pulses expected", 256'(exp_fd), 256'(5));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
